// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and types for the frame reader and its raster generator.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BACK  = 48;
    localparam int DEF_H_DISP  = 640;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 33;
    localparam int DEF_V_DISP  = 480;
    localparam int DEF_V_FRONT = 10;

    localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_DISP + DEF_H_FRONT;
    localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_DISP + DEF_V_FRONT;
    localparam int HA0     = DEF_H_SYNC + DEF_H_BACK;
    localparam int VA0     = DEF_V_SYNC + DEF_V_BACK;

    localparam logic [15:0] BLACK = 16'h0000;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

endpackage

// File: rtl/vga_frame_reader_timing_gen.sv
// Raster counters plus the sync/active/frame-origin decode.
// Counters only advance while count_en is high and snap back to the origin otherwise.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FRONT = DEF_V_FRONT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic count_en,
    output logic hs,
    output logic vs,
    output logic active,
    output logic frame_start
);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [CNT_W-1:0] H_SYNCC = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNCC = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT0  = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT1  = CNT_W'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CNT_W-1:0] V_ACT0  = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT1  = CNT_W'(V_SYNC + V_BACK + V_DISP);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!count_en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        hs          = (h_cnt >= H_SYNCC);
        vs          = (v_cnt >= V_SYNCC);
        active      = run && (h_cnt >= H_ACT0) && (h_cnt < H_ACT1)
                          && (v_cnt >= V_ACT0) && (v_cnt < V_ACT1);
        frame_start = run && (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Pulls RGB565 pixels from the SDRAM read FIFO and drives VGA pins through a 2-stage pipeline.
// Dropping sdram_init_done returns to IDLE and flushes the raster back to reset values.
module vga_frame_reader
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FRONT = DEF_V_FRONT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic [15:0] sdram_rd_data,
    input  logic        sdram_rd_empty,
    output logic        sdram_rd_req,
    output logic        frame_start,
    output logic        underflow,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [15:0] vga_rgb
);

    state_t state, state_nxt;
    logic   run;
    logic   count_en;
    logic   dec_hs, dec_vs, dec_active;
    logic   s1_hs, s1_vs, s1_active, s1_emp;

    assign run      = (state == ST_RUN);
    assign count_en = run && sdram_init_done;

    vga_timing_gen #(
        .H_SYNC (H_SYNC),
        .H_BACK (H_BACK),
        .H_DISP (H_DISP),
        .H_FRONT(H_FRONT),
        .V_SYNC (V_SYNC),
        .V_BACK (V_BACK),
        .V_DISP (V_DISP),
        .V_FRONT(V_FRONT)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .count_en   (count_en),
        .hs         (dec_hs),
        .vs         (dec_vs),
        .active     (dec_active),
        .frame_start(frame_start)
    );

    assign sdram_rd_req = dec_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (sdram_init_done)  state_nxt = ST_RUN;
            ST_RUN:  if (!sdram_init_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Both stages clear together with the counters so no partial pixel survives a stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !count_en) begin
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_active <= 1'b0;
            s1_emp    <= 1'b0;
        end else begin
            s1_hs     <= dec_hs;
            s1_vs     <= dec_vs;
            s1_active <= dec_active;
            s1_emp    <= sdram_rd_req && sdram_rd_empty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !count_en) begin
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
            vga_de  <= 1'b0;
            vga_rgb <= BLACK;
        end else begin
            vga_hs  <= s1_hs;
            vga_vs  <= s1_vs;
            vga_de  <= s1_active;
            vga_rgb <= (s1_active && !s1_emp) ? sdram_rd_data : BLACK;
        end
    end

    // A pop from an empty FIFO outranks the frame-origin clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !count_en)                  underflow <= 1'b0;
        else if (sdram_rd_req && sdram_rd_empty)  underflow <= 1'b1;
        else if (frame_start)                     underflow <= 1'b0;
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader using a reduced raster so whole frames run quickly.
// Expected outputs come from a position-based model: (h, v) = cycle index mod line/frame size.
module tb_vga_frame_reader;

    localparam int HS = 4, HB = 3, HD = 10, HF = 2;
    localparam int VS = 2, VB = 2, VD = 6,  VF = 1;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int HA = HS + HB;
    localparam int VA = VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdram_init_done = 1'b0;
    logic [15:0] sdram_rd_data = 16'h0000;
    logic        sdram_rd_empty = 1'b0;
    logic        sdram_rd_req, frame_start, underflow;
    logic        vga_hs, vga_vs, vga_de;
    logic [15:0] vga_rgb;
    logic [15:0] fifo_next = 16'h3a70;

    int total = 0;
    int bad = 0;

    vga_frame_reader #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sdram_init_done(sdram_init_done),
        .sdram_rd_data  (sdram_rd_data),
        .sdram_rd_empty (sdram_rd_empty),
        .sdram_rd_req   (sdram_rd_req),
        .frame_start    (frame_start),
        .underflow      (underflow),
        .vga_hs         (vga_hs),
        .vga_vs         (vga_vs),
        .vga_de         (vga_de),
        .vga_rgb        (vga_rgb)
    );

    always #5 clk = ~clk;

    // Non-show-ahead FIFO: a pop presents the next word on the following cycle.
    always @(posedge clk) begin
        if (sdram_rd_req && !sdram_rd_empty) begin
            sdram_rd_data <= fifo_next;
            fifo_next     <= fifo_next + 16'd1;
        end
    end

    function automatic bit in_active(input int k);
        int h, v;
        h = k % HT;
        v = (k / HT) % VT;
        return (h >= HA) && (h < HA + HD) && (v >= VA) && (v < VA + VD);
    endfunction

    // Starts the raster from IDLE and checks every cycle k = 0..ncyc-1 against the model.
    // Output-side counts cover k >= 2, input-side counts cover k < ncyc-2.
    task automatic run_raster(input int ncyc, input int inj,
                              output int pops, output int de_cnt, output int hs_low,
                              output int vs_low, output int fs_cnt);
        logic [15:0] exp_pix[$];
        logic [15:0] nxt, e_rgb;
        bit          uf, act, fs, emp, e_hs, e_vs, e_de;
        int          kp;
        nxt = fifo_next;
        uf = 1'b0;
        pops = 0; de_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0;
        sdram_init_done = 1'b1;
        @(posedge clk);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            emp = (k == inj);
            sdram_rd_empty = emp;
            act = in_active(k);
            fs  = (k % FRAME) == 0;
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 16'h0000;
            if (k >= 2) begin
                kp   = k - 2;
                e_hs = (kp % HT) >= HS;
                e_vs = ((kp / HT) % VT) >= VS;
                e_de = in_active(kp);
                if (e_de && exp_pix.size() > 0) e_rgb = exp_pix.pop_front();
            end
            total++;
            if ({sdram_rd_req, frame_start, underflow} !== {act, fs, uf}) begin
                bad++;
                $display("[TB] FAIL ctrl k=%0d req/fs/uf got=%b%b%b exp=%b%b%b",
                         k, sdram_rd_req, frame_start, underflow, act, fs, uf);
            end
            total++;
            if ({vga_hs, vga_vs, vga_de, vga_rgb} !== {e_hs, e_vs, e_de, e_rgb}) begin
                bad++;
                $display("[TB] FAIL video k=%0d hs/vs/de/rgb got=%b%b%b/%h exp=%b%b%b/%h",
                         k, vga_hs, vga_vs, vga_de, vga_rgb, e_hs, e_vs, e_de, e_rgb);
            end
            if (act) begin
                if (emp) exp_pix.push_back(16'h0000);
                else begin
                    exp_pix.push_back(nxt);
                    nxt = nxt + 16'd1;
                end
            end
            if (act && emp) uf = 1'b1;
            else if (fs)    uf = 1'b0;
            if (k < ncyc - 2) begin
                if (sdram_rd_req) pops++;
                if (frame_start)  fs_cnt++;
            end
            if (k >= 2) begin
                if (vga_de)  de_cnt++;
                if (!vga_hs) hs_low++;
                if (!vga_vs) vs_low++;
            end
        end
        sdram_rd_empty = 1'b0;
    endtask

    task automatic go_idle();
        sdram_init_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        $display("[TB] reset and idle hold");
        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            total++;
            if ({sdram_rd_req, frame_start, underflow, vga_hs, vga_vs, vga_de, vga_rgb}
                    !== {3'b000, 3'b110, 16'h0000}) begin
                bad++;
                $display("[TB] FAIL idle cycle=%0d got=%b%b%b%b%b%b/%h exp=000110/0000", i,
                         sdram_rd_req, frame_start, underflow, vga_hs, vga_vs, vga_de, vga_rgb);
            end
        end
    endtask

    task automatic test_stream();
        int pops, de_cnt, hs_low, vs_low, fs_cnt;
        $display("[TB] two clean frames");
        run_raster(2 * FRAME + 2, -1, pops, de_cnt, hs_low, vs_low, fs_cnt);
        total++;
        if (pops !== 2 * HD * VD) begin
            bad++; $display("[TB] FAIL pop_count got=%0d exp=%0d", pops, 2 * HD * VD);
        end
        total++;
        if (de_cnt !== 2 * HD * VD) begin
            bad++; $display("[TB] FAIL de_count got=%0d exp=%0d", de_cnt, 2 * HD * VD);
        end
        total++;
        if (hs_low !== 2 * HS * VT) begin
            bad++; $display("[TB] FAIL hs_low got=%0d exp=%0d", hs_low, 2 * HS * VT);
        end
        total++;
        if (vs_low !== 2 * VS * HT) begin
            bad++; $display("[TB] FAIL vs_low got=%0d exp=%0d", vs_low, 2 * VS * HT);
        end
        total++;
        if (fs_cnt !== 2) begin
            bad++; $display("[TB] FAIL frame_start_count got=%0d exp=2", fs_cnt);
        end
        go_idle();
    endtask

    task automatic test_underflow();
        int pops, de_cnt, hs_low, vs_low, fs_cnt, line, px;
        for (int r = 0; r < 3; r++) begin
            line = VA + $urandom_range(0, VD - 1);
            px   = HA + $urandom_range(0, HD - 1);
            $display("[TB] empty pop at line %0d pixel %0d", line, px);
            run_raster(2 * FRAME + 2, line * HT + px, pops, de_cnt, hs_low, vs_low, fs_cnt);
            go_idle();
        end
    endtask

    task automatic test_drop();
        int pops, de_cnt, hs_low, vs_low, fs_cnt, kd;
        kd = (VA + $urandom_range(1, VD - 1)) * HT + HA + $urandom_range(0, HD - 1);
        $display("[TB] init_done drop at cycle %0d", kd);
        run_raster(kd + 1, -1, pops, de_cnt, hs_low, vs_low, fs_cnt);
        sdram_init_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({sdram_rd_req, frame_start, underflow, vga_hs, vga_vs, vga_de, vga_rgb}
                !== {3'b000, 3'b110, 16'h0000}) begin
            bad++;
            $display("[TB] FAIL drop_flush got=%b%b%b%b%b%b/%h exp=000110/0000",
                     sdram_rd_req, frame_start, underflow, vga_hs, vga_vs, vga_de, vga_rgb);
        end
        run_raster(FRAME + 2, -1, pops, de_cnt, hs_low, vs_low, fs_cnt);
        total++;
        if (pops !== HD * VD) begin
            bad++; $display("[TB] FAIL restart_pops got=%0d exp=%0d", pops, HD * VD);
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        int pops, de_cnt, hs_low, vs_low, fs_cnt, kr;
        kr = (VA + 1) * HT + HA + $urandom_range(2, HD - 1);
        $display("[TB] async reset at cycle %0d", kr);
        run_raster(kr + 1, kr - 1, pops, de_cnt, hs_low, vs_low, fs_cnt);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({sdram_rd_req, frame_start, underflow, vga_hs, vga_vs, vga_de, vga_rgb}
                !== {3'b000, 3'b110, 16'h0000}) begin
            bad++;
            $display("[TB] FAIL async_reset got=%b%b%b%b%b%b/%h exp=000110/0000",
                     sdram_rd_req, frame_start, underflow, vga_hs, vga_vs, vga_de, vga_rgb);
        end
        sdram_init_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({sdram_rd_req, vga_de} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL post_reset_idle cycle=%0d req/de got=%b%b exp=00",
                         i, sdram_rd_req, vga_de);
            end
        end
        run_raster(FRAME + 2, -1, pops, de_cnt, hs_low, vs_low, fs_cnt);
        go_idle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_underflow();
        test_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Read-side counterpart of the edge-detection write path. It generates VGA raster timing and pulls RGB565 pixels from the SDRAM controller's read FIFO, one pixel per active clock. It drives the VGA pins with hsync, vsync, data-enable and pixel data, aligned in a fixed pipeline. It sits between the SDRAM read port and the VGA DAC/connector, in the pixel clock domain (25 MHz for 640x480@60).

## Interface
Parameters:
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 48, horizontal back porch
- H_DISP, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch
- V_DISP, 480, active lines
- V_FRONT, 10, vertical front porch

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- sdram_init_done  in  1  SDRAM ready; level enable for the raster
- sdram_rd_data  in  16  read FIFO output; valid the cycle after sdram_rd_req, non-show-ahead
- sdram_rd_empty  in  1  read FIFO empty flag
- sdram_rd_req  out  1  read FIFO pop, one per active pixel
- frame_start  out  1  one-cycle pulse at raster origin; rewinds the SDRAM read address
- underflow  out  1  sticky flag: a pop occurred while the FIFO was empty in the current frame
- vga_hs  out  1  hsync, active-low
- vga_vs  out  1  vsync, active-low
- vga_de  out  1  active-video enable
- vga_rgb  out  16  RGB565 pixel; 0 outside active video

## Operation
- Derived constants:
  - H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
  - HA0 = H_SYNC + H_BACK (144); VA0 = V_SYNC + V_BACK (35).
- States:
  - IDLE: counters are held at 0, all outputs are at their reset values.
  - RUN: counters advance.
- State transitions:
  - IDLE -> RUN when sdram_init_done = 1. The first RUN cycle has h_cnt = v_cnt = 0.
  - RUN -> IDLE on the first cycle sdram_init_done = 0, from any position. Counters clear and the pipeline flushes to reset values.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 and wraps to 0.
  - Widths are 10 bits each.
- Active region: HA0 <= h_cnt < HA0 + H_DISP and VA0 <= v_cnt < VA0 + V_DISP.
- sdram_rd_req is a combinational decode of the active region at the current counter value. This gives exactly H_DISP x V_DISP pops per frame.
- Pipeline stage 1 registers sync, active and empty-at-pop:
  - hs = (h_cnt >= H_SYNC)
  - vs = (v_cnt >= V_SYNC)
  - active
  - emp = sdram_rd_req & sdram_rd_empty
- Pipeline stage 2 drives the outputs:
  - vga_hs, vga_vs and vga_de come from stage 1.
  - vga_rgb = sdram_rd_data when stage-1 active = 1 and stage-1 emp = 0; otherwise vga_rgb = 16'h0000.
- frame_start = 1 for one cycle when RUN, h_cnt = 0 and v_cnt = 0. It is combinational from the counters.
- underflow:
  - Set on the cycle after any pop with sdram_rd_empty = 1.
  - Cleared on frame_start.
  - If a set and the clear fall in the same cycle, the set wins.
- Reset values: sdram_rd_req 0, frame_start 0, underflow 0, vga_hs 1, vga_vs 1, vga_de 0, vga_rgb 0. The state is IDLE.

## Timing
- Video outputs lag the counters by exactly 2 clocks.
- sdram_rd_req leads vga_de by 2 clocks.
- FIFO data read-to-use latency is 1 clock, captured into the vga_rgb register.
- The first pop of a frame is at h_cnt = 144, v_cnt = 35. The first vga_de = 1 appears 2 clocks later.
- Per line: vga_hs is low for 96 clocks and vga_de is high for 640 consecutive clocks.
- Per frame:
  - vga_vs is low for 2 x 800 clocks.
  - The frame period is 420000 clocks.
  - frame_start pulses once.
- On RUN -> IDLE, the stage registers clear in the same cycle as the counters, so no partial pixel is output afterwards.

## Structure
- Shared package vga_timing_pkg holds:
  - the default 640x480@60 timing constants
  - H_TOTAL, V_TOTAL, HA0, VA0
  - BLACK = 16'h0000
  - the counter width of 10
- Sub-module vga_timing_gen holds the counters and the decode of hs, vs, active and frame_start, gated by the RUN enable.
- The top level contains the IDLE/RUN control, the 2-stage pixel pipeline and the underflow flag.

## Test plan
- Reset held, then released with sdram_init_done = 0:
  - vga_hs = vga_vs = 1, vga_de = 0, vga_rgb = 0, sdram_rd_req = 0 for 1000 clocks.
- sdram_init_done = 1, FIFO never empty, sdram_rd_data = incrementing count:
  - 307200 pops per frame.
  - vga_de high 640 clocks per line on 480 lines.
  - vga_rgb on each vga_de cycle equals the value popped 2 clocks earlier.
- Full-frame sync check:
  - vga_hs low 96 of every 800 clocks.
  - vga_vs low 1600 of every 420000 clocks.
  - frame_start exactly once per 420000 clocks, at the first RUN cycle.
- sdram_rd_empty = 1 for one pop at line 100, pixel 10:
  - That output pixel is 16'h0000.
  - underflow goes to 1 on the following cycle and holds until the next frame_start, then returns to 0.
- sdram_init_done dropped mid-line (h_cnt = 400, v_cnt = 200), then restored:
  - Next cycle: all outputs are at reset values.
  - On restore, the raster restarts with frame_start and the first pop at (144, 35).
- rst_n asserted mid-active-video:
  - All outputs are at reset values immediately (asynchronous), with no pops until sdram_init_done is seen after release.
